// File: rtl/sync_evt_pkg.sv
// Shared types and constants for the synchronised edge/event capture stage.
package sync_evt_pkg;

    // Glitch filter state: STABLE tracks level_q, QUALIFY counts differing samples.
    typedef enum logic {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } filt_state_t;

    // Event record polarity encoding.
    localparam logic EVT_RISE = 1'b1;
    localparam logic EVT_FALL = 1'b0;

endpackage

// File: rtl/sync_glitch_filter.sv
// Glitch filter for a synchronised level. A new level is accepted after
// FILTER_CYCLES consecutive samples that differ from level_q. 'accept' is
// a combinational strobe, high in the cycle whose closing edge updates level_q.
module sync_glitch_filter
    import sync_evt_pkg::*;
#(
    parameter int FILTER_CYCLES = 2
) (
    input  logic clk_b,
    input  logic rst_b,
    input  logic signal_b,
    input  logic filter_en,
    output logic level_q,
    output logic accept
);

    localparam int FC_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_CYCLES);

    filt_state_t     state;
    filt_state_t     state_nxt;
    logic [FC_W-1:0] filt_cnt;
    logic [FC_W-1:0] filt_cnt_nxt;

    // Next-state, qualify counter and accept decision.
    always_comb begin
        // NOTE: every always_comb output is given a default first so no latch is inferred.
        state_nxt    = state;
        filt_cnt_nxt = filt_cnt;
        accept       = 1'b0;
        if (!filter_en) begin
            // Bypass: follow signal_b directly, keep the FSM parked.
            state_nxt    = STABLE;
            filt_cnt_nxt = '0;
            accept       = (signal_b != level_q);
        end else begin
            case (state)
                STABLE: begin
                    if (signal_b != level_q) begin
                        if (FILTER_CYCLES == 1) begin
                            accept = 1'b1;
                        end else begin
                            state_nxt    = QUALIFY;
                            filt_cnt_nxt = FC_W'(1);
                        end
                    end
                end
                QUALIFY: begin
                    if (signal_b == level_q) begin
                        // Glitch: input returned before qualifying.
                        state_nxt    = STABLE;
                        filt_cnt_nxt = '0;
                    end else if (filt_cnt + FC_W'(1) == FC_LAST) begin
                        accept       = 1'b1;
                        state_nxt    = STABLE;
                        filt_cnt_nxt = '0;
                    end else begin
                        filt_cnt_nxt = filt_cnt + FC_W'(1);
                    end
                end
                default: begin
                    state_nxt    = STABLE;
                    filt_cnt_nxt = '0;
                end
            endcase
        end
    end

    // State, counter and filtered level registers.
    always_ff @(posedge clk_b) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_b) begin
            state    <= STABLE;
            filt_cnt <= '0;
            level_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            filt_cnt <= filt_cnt_nxt;
            if (accept) begin
                level_q <= signal_b;
            end
        end
    end

endmodule

// File: rtl/sync_edge_event_capture.sv
// Edge/event capture stage downstream of a two-flop level synchroniser.
// Filters the level, emits rise/fall pulses, counts edges (saturating),
// holds one event record on a valid/ready interface and flags overrun.
// Optional feature: define SYNC_EVT_TIMESTAMP_EN to add a free-running
// timestamp counter and the evt_ts output.
module sync_edge_event_capture
    import sync_evt_pkg::*;
#(
    parameter int FILTER_CYCLES = 2,
    parameter int CNT_W         = 16
`ifdef SYNC_EVT_TIMESTAMP_EN
    ,
    parameter int TS_W          = 16
`endif
) (
    input  logic             clk_b,
    input  logic             rst_b,
    input  logic             signal_b,
    input  logic             filter_en,
    input  logic             clr_counts,
    output logic             level_q,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] rise_count,
    output logic [CNT_W-1:0] fall_count,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_is_rise,
`ifdef SYNC_EVT_TIMESTAMP_EN
    output logic [TS_W-1:0]  evt_ts,
`endif
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic accept;
    logic accept_rise;
    logic accept_fall;
    logic load_evt;
    logic drop_evt;

    sync_glitch_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
        .clk_b    (clk_b),
        .rst_b    (rst_b),
        .signal_b (signal_b),
        .filter_en(filter_en),
        .level_q  (level_q),
        .accept   (accept)
    );

    // On accept the new level equals signal_b, which gives the edge direction.
    assign accept_rise = accept && (signal_b == EVT_RISE);
    assign accept_fall = accept && (signal_b == EVT_FALL);
    // The single slot is free if empty or being drained this same cycle.
    assign load_evt    = accept && (!evt_valid || evt_ready);
    assign drop_evt    = accept && evt_valid && !evt_ready;

    // One-cycle edge pulses, coincident with the updated level_q.
    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= accept_rise;
            fall_pulse <= accept_fall;
        end
    end

    // Saturating edge counters; a clear coincident with an edge counts that edge.
    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            rise_count <= '0;
            fall_count <= '0;
        end else if (clr_counts) begin
            rise_count <= accept_rise ? CNT_W'(1) : '0;
            fall_count <= accept_fall ? CNT_W'(1) : '0;
        end else begin
            if (accept_rise && rise_count != CNT_MAX) rise_count <= rise_count + CNT_W'(1);
            if (accept_fall && fall_count != CNT_MAX) fall_count <= fall_count + CNT_W'(1);
        end
    end

    // Single-entry event record; held stable until handshaken.
    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            evt_valid   <= 1'b0;
            evt_is_rise <= EVT_FALL;
        end else if (load_evt) begin
            evt_valid   <= 1'b1;
            evt_is_rise <= accept_rise ? EVT_RISE : EVT_FALL;
        end else if (evt_valid && evt_ready) begin
            evt_valid   <= 1'b0;
        end
    end

    // Sticky overrun; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            overrun <= 1'b0;
        end else if (drop_evt) begin
            overrun <= 1'b1;
        end else if (clr_counts) begin
            overrun <= 1'b0;
        end
    end

`ifdef SYNC_EVT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    // Free-running wrapping timestamp; the record captures its pre-increment value.
    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            ts_cnt <= '0;
            evt_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (load_evt) begin
                evt_ts <= ts_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_edge_event_capture.sv
// Directed testbench for sync_edge_event_capture. Instance dut uses
// FILTER_CYCLES=2, CNT_W=4 (TS_W=4 when SYNC_EVT_TIMESTAMP_EN is defined);
// instance dut3 uses FILTER_CYCLES=3 for the glitch scenarios.
module tb_sync_edge_event_capture;

    logic       clk_b = 1'b0;
    logic       rst_b;
    logic       sig, fen, clr, rdy;
    logic       lvl, rp, fp, ev, eir, ovr;
    logic [3:0] rc, fc;
    logic        sig3, fen3, clr3, rdy3;
    logic        lvl3, rp3, fp3, ev3, eir3, ovr3;
    logic [15:0] rc3, fc3;
`ifdef SYNC_EVT_TIMESTAMP_EN
    logic [3:0]  ets;
    logic [15:0] ets3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_b = ~clk_b;

    sync_edge_event_capture #(
        .FILTER_CYCLES(2),
        .CNT_W(4)
`ifdef SYNC_EVT_TIMESTAMP_EN
        ,
        .TS_W(4)
`endif
    ) dut (
        .clk_b(clk_b), .rst_b(rst_b), .signal_b(sig), .filter_en(fen),
        .clr_counts(clr), .level_q(lvl), .rise_pulse(rp), .fall_pulse(fp),
        .rise_count(rc), .fall_count(fc), .evt_valid(ev), .evt_ready(rdy),
        .evt_is_rise(eir),
`ifdef SYNC_EVT_TIMESTAMP_EN
        .evt_ts(ets),
`endif
        .overrun(ovr)
    );

    sync_edge_event_capture #(
        .FILTER_CYCLES(3),
        .CNT_W(16)
    ) dut3 (
        .clk_b(clk_b), .rst_b(rst_b), .signal_b(sig3), .filter_en(fen3),
        .clr_counts(clr3), .level_q(lvl3), .rise_pulse(rp3), .fall_pulse(fp3),
        .rise_count(rc3), .fall_count(fc3), .evt_valid(ev3), .evt_ready(rdy3),
        .evt_is_rise(eir3),
`ifdef SYNC_EVT_TIMESTAMP_EN
        .evt_ts(ets3),
`endif
        .overrun(ovr3)
    );

    // Inputs are set before calling step; step returns at the following
    // negedge, after one posedge has consumed them.
    task automatic step();
        @(negedge clk_b);
    endtask

    task automatic test_reset();
        rst_b = 1'b1; sig = 1'b1; fen = 1'b1; clr = 1'b0; rdy = 1'b0;
        sig3 = 1'b0; fen3 = 1'b1; clr3 = 1'b0; rdy3 = 1'b1;
        step(); step();
        checks++; if (lvl !== 1'b0) begin errors++; $display("FAIL rst_level got=%0b exp=0", lvl); end
        checks++; if (rp !== 1'b0 || fp !== 1'b0) begin errors++; $display("FAIL rst_pulses got=%0b%0b exp=00", rp, fp); end
        checks++; if (rc !== 4'd0 || fc !== 4'd0) begin errors++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", rc, fc); end
        checks++; if (ev !== 1'b0 || ovr !== 1'b0) begin errors++; $display("FAIL rst_evt got=%0b ovr=%0b exp=0/0", ev, ovr); end
        rst_b = 1'b0;
        step();
        checks++; if (lvl !== 1'b0 || rp !== 1'b0) begin errors++; $display("FAIL t1_edge1 got lvl=%0b rp=%0b exp=0/0", lvl, rp); end
        step();
        checks++; if (lvl !== 1'b1 || rp !== 1'b1) begin errors++; $display("FAIL t1_edge2 got lvl=%0b rp=%0b exp=1/1", lvl, rp); end
        checks++; if (rc !== 4'd1 || fc !== 4'd0) begin errors++; $display("FAIL t1_counts got=%0d/%0d exp=1/0", rc, fc); end
        checks++; if (ev !== 1'b1 || eir !== 1'b1) begin errors++; $display("FAIL t1_record got v=%0b r=%0b exp=1/1", ev, eir); end
        step();
        checks++; if (rp !== 1'b0 || ev !== 1'b1) begin errors++; $display("FAIL t1_pulse_end got rp=%0b v=%0b exp=0/1", rp, ev); end
        rdy = 1'b1;
        step();
        checks++; if (ev !== 1'b0) begin errors++; $display("FAIL t1_handshake got=%0b exp=0", ev); end
        rdy = 1'b0;
    endtask

    task automatic test_glitch();
        sig3 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (rp3 !== 1'b0 || lvl3 !== 1'b0) begin errors++; $display("FAIL t2_glitch_hi%0d got rp=%0b lvl=%0b exp=0/0", i, rp3, lvl3); end
        end
        sig3 = 1'b0;
        step(); step();
        checks++; if (lvl3 !== 1'b0 || rp3 !== 1'b0 || fp3 !== 1'b0) begin errors++; $display("FAIL t2_glitch_after got lvl=%0b rp=%0b fp=%0b exp=0/0/0", lvl3, rp3, fp3); end
        checks++; if (rc3 !== 16'd0 || fc3 !== 16'd0) begin errors++; $display("FAIL t2_glitch_counts got=%0d/%0d exp=0/0", rc3, fc3); end
        fen3 = 1'b0; sig3 = 1'b1;
        step();
        checks++; if (lvl3 !== 1'b1 || rp3 !== 1'b1) begin errors++; $display("FAIL t2_bypass_rise got lvl=%0b rp=%0b exp=1/1", lvl3, rp3); end
        sig3 = 1'b0;
        step();
        checks++; if (lvl3 !== 1'b0 || fp3 !== 1'b1 || rp3 !== 1'b0) begin errors++; $display("FAIL t2_bypass_fall got lvl=%0b fp=%0b rp=%0b exp=0/1/0", lvl3, fp3, rp3); end
        checks++; if (rc3 !== 16'd1 || fc3 !== 16'd1) begin errors++; $display("FAIL t2_bypass_counts got=%0d/%0d exp=1/1", rc3, fc3); end
        checks++; if (ovr3 !== 1'b0 || eir3 !== 1'b0) begin errors++; $display("FAIL t2_bypass_evt got ovr=%0b r=%0b exp=0/0", ovr3, eir3); end
        fen3 = 1'b1;
    endtask

    task automatic test_overrun();
        clr = 1'b1; step(); clr = 1'b0;
        checks++; if (rc !== 4'd0 || ovr !== 1'b0) begin errors++; $display("FAIL t3_clear got rc=%0d ovr=%0b exp=0/0", rc, ovr); end
        sig = 1'b0; step(); step();
        checks++; if (ev !== 1'b1 || eir !== 1'b0 || fp !== 1'b1) begin errors++; $display("FAIL t3_first got v=%0b r=%0b fp=%0b exp=1/0/1", ev, eir, fp); end
        sig = 1'b1; step(); step();
        sig = 1'b0; step(); step();
        checks++; if (ev !== 1'b1 || eir !== 1'b0) begin errors++; $display("FAIL t3_held got v=%0b r=%0b exp=1/0", ev, eir); end
        checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL t3_overrun got=%0b exp=1", ovr); end
        checks++; if (rc !== 4'd1 || fc !== 4'd2) begin errors++; $display("FAIL t3_counts got=%0d/%0d exp=1/2 (total 3)", rc, fc); end
        rdy = 1'b1; step();
        checks++; if (ev !== 1'b0) begin errors++; $display("FAIL t3_drain got=%0b exp=0", ev); end
        step();
        checks++; if (ev !== 1'b0 || ovr !== 1'b1) begin errors++; $display("FAIL t3_idle got v=%0b ovr=%0b exp=0/1", ev, ovr); end
        rdy = 1'b0;
    endtask

    task automatic test_back_to_back();
        clr = 1'b1; step(); clr = 1'b0;
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL t4_ovr_clear got=%0b exp=0", ovr); end
        sig = 1'b1; step(); step();
        checks++; if (ev !== 1'b1 || eir !== 1'b1) begin errors++; $display("FAIL t4_first got v=%0b r=%0b exp=1/1", ev, eir); end
        sig = 1'b0; step();
        rdy = 1'b1; step();
        checks++; if (ev !== 1'b1 || eir !== 1'b0 || fp !== 1'b1) begin errors++; $display("FAIL t4_reload got v=%0b r=%0b fp=%0b exp=1/0/1", ev, eir, fp); end
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL t4_no_overrun got=%0b exp=0", ovr); end
        step();
        checks++; if (ev !== 1'b0) begin errors++; $display("FAIL t4_drain got=%0b exp=0", ev); end
        rdy = 1'b0;
    endtask

    task automatic test_saturate();
        clr = 1'b1; step(); clr = 1'b0;
        rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sig = 1'b1; step(); step();
            sig = 1'b0; step(); step();
        end
        checks++; if (rc !== 4'd15 || fc !== 4'd15) begin errors++; $display("FAIL t5_saturate got=%0d/%0d exp=15/15", rc, fc); end
        step();
        sig = 1'b1; step();
        clr = 1'b1; step(); clr = 1'b0;
        checks++; if (rc !== 4'd1 || fc !== 4'd0 || rp !== 1'b1) begin errors++; $display("FAIL t5_clr_rise got=%0d/%0d rp=%0b exp=1/0/1", rc, fc, rp); end
        checks++; if (ovr !== 1'b0 || ev !== 1'b1) begin errors++; $display("FAIL t5_clr_evt got ovr=%0b v=%0b exp=0/1", ovr, ev); end
        rdy = 1'b0;
        sig = 1'b0; step();
        clr = 1'b1; step(); clr = 1'b0;
        checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL t5_set_beats_clr got=%0b exp=1", ovr); end
        checks++; if (rc !== 4'd0 || fc !== 4'd1 || eir !== 1'b1) begin errors++; $display("FAIL t5_clr_fall got=%0d/%0d r=%0b exp=0/1/1", rc, fc, eir); end
        rdy = 1'b1; step(); rdy = 1'b0;
    endtask

`ifdef SYNC_EVT_TIMESTAMP_EN
    task automatic test_timestamp();
        rst_b = 1'b1; sig = 1'b0; rdy = 1'b1; step();
        rst_b = 1'b0;
        sig = 1'b1; step(); step();
        checks++; if (ev !== 1'b1 || ets !== 4'd1) begin errors++; $display("FAIL t6_ts_first got v=%0b ts=%0d exp=1/1", ev, ets); end
        for (int i = 0; i < 16; i++) step();
        sig = 1'b0; step(); step();
        checks++; if (ev !== 1'b1 || ets !== 4'd3) begin errors++; $display("FAIL t6_ts_wrap got v=%0b ts=%0d exp=1/3", ev, ets); end
        step(); rdy = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_qualify();
        rst_b = 1'b0; sig = 1'b1; clr = 1'b0; rdy = 1'b0;
        step();
        rst_b = 1'b1; step();
        checks++; if (lvl !== 1'b0 || rp !== 1'b0 || fp !== 1'b0 || ev !== 1'b0 || eir !== 1'b0 || ovr !== 1'b0) begin errors++; $display("FAIL t6_rst_outputs got lvl=%0b rp=%0b fp=%0b v=%0b r=%0b ovr=%0b exp=all 0", lvl, rp, fp, ev, eir, ovr); end
        checks++; if (rc !== 4'd0 || fc !== 4'd0) begin errors++; $display("FAIL t6_rst_counts got=%0d/%0d exp=0/0", rc, fc); end
`ifdef SYNC_EVT_TIMESTAMP_EN
        checks++; if (ets !== 4'd0) begin errors++; $display("FAIL t6_rst_ts got=%0d exp=0", ets); end
`endif
        rst_b = 1'b0; step();
        checks++; if (lvl !== 1'b0) begin errors++; $display("FAIL t6_requal_edge1 got=%0b exp=0", lvl); end
        step();
        checks++; if (lvl !== 1'b1 || rp !== 1'b1 || rc !== 4'd1) begin errors++; $display("FAIL t6_requal_edge2 got lvl=%0b rp=%0b rc=%0d exp=1/1/1", lvl, rp, rc); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_overrun();
        test_back_to_back();
        test_saturate();
`ifdef SYNC_EVT_TIMESTAMP_EN
        test_timestamp();
`endif
        test_reset_mid_qualify();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
